// File: rtl/cache_mem_arbiter_if.sv
// Request/fill and memory-bus signals shared between the caches, the arbiter and memory.
// The arbiter connects through the slave modport; caches/memory models use master.
interface cache_mem_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 8
);
  localparam int WL = $clog2(WORDS_PER_LINE);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_wr;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        fill_valid;
  logic [DATA_W-1:0]           fill_data;
  logic [WL-1:0]               fill_word;
  logic [NUM_PORTS-1:0]        fill_done;
  logic [NUM_PORTS-1:0]        wr_done;
  logic                        busy;
  logic                        mem_en;
  logic                        mem_wr;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        mem_rvalid;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
    output req_ready, fill_valid, fill_data, fill_word, fill_done, wr_done,
           busy, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
    input  req_ready, fill_valid, fill_data, fill_word, fill_done, wr_done,
           busy, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates NUM_PORTS caches onto one pipelined word memory: line fills for read
// misses, single-word write-throughs for stores, fixed-priority or round-robin grant.
module cache_mem_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int MEM_LATENCY    = 4,
  parameter int ARB_MODE       = 1
) (
  input logic clk,
  input logic rst_n,
  cache_mem_arbiter_if.slave bus
);
  localparam int WL = $clog2(WORDS_PER_LINE);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = WL + 1;
  localparam logic [CW-1:0] LINE = CW'(WORDS_PER_LINE);
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);

  if (NUM_PORTS < 2 || WORDS_PER_LINE < 2 ||
      (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0 || MEM_LATENCY < 1) begin : g_param_check
    $error("cache_mem_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, WR, FILL} state_t;

  state_t            state;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     rr_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     ret_cnt;
  logic              grant_valid;
  logic [PW-1:0]     grant_idx;
  logic [ADDR_W-1:0] line_base;

  assign line_base = {addr_q[ADDR_W-1:WL], {WL{1'b0}}};

  // Round-robin searches upward from the slot after the last winner, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (ARB_MODE == 0) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (bus.req_valid[p]) begin
          grant_valid = 1'b1;
          grant_idx   = PW'(p);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (!grant_valid && bus.req_valid[(int'(rr_ptr) + k) % NUM_PORTS]) begin
          grant_valid = 1'b1;
          grant_idx   = PW'((int'(rr_ptr) + k) % NUM_PORTS);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.fill_valid = '0;
    bus.fill_data  = '0;
    bus.fill_word  = '0;
    bus.fill_done  = '0;
    bus.wr_done    = '0;
    bus.busy       = (state != IDLE);
    bus.mem_en     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (grant_valid && rst_n) bus.req_ready[grant_idx] = 1'b1;
      end
      WR: begin
        bus.mem_en         = 1'b1;
        bus.mem_wr         = 1'b1;
        bus.mem_addr       = addr_q;
        bus.mem_wdata      = wdata_q;
        bus.wr_done[owner] = 1'b1;
      end
      FILL: begin
        if (issue_cnt < LINE) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = line_base + ADDR_W'(issue_cnt);
        end
        if (bus.mem_rvalid && ret_cnt < LINE) begin
          bus.fill_valid[owner] = 1'b1;
          bus.fill_data         = bus.mem_rdata;
          bus.fill_word         = ret_cnt[WL-1:0];
          if (ret_cnt == LAST) bus.fill_done[owner] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Issues and returns are counted independently; the last return closes the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= PW'(NUM_PORTS - 1);
      addr_q    <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_idx;
            rr_ptr    <= grant_idx;
            addr_q    <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            wdata_q   <= bus.req_wdata[grant_idx*DATA_W +: DATA_W];
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= bus.req_wr[grant_idx] ? WR : FILL;
          end
        end
        WR: state <= IDLE;
        FILL: begin
          if (issue_cnt < LINE) issue_cnt <= issue_cnt + 1'b1;
          if (bus.mem_rvalid && ret_cnt < LINE) begin
            if (ret_cnt == LAST) begin
              state     <= IDLE;
              issue_cnt <= '0;
              ret_cnt   <= '0;
            end else begin
              ret_cnt <= ret_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Parametrised successor to the two-cache memory controller.
- Arbitrates NUM_PORTS cache requesters (port 0 = D-cache, port 1 = I-cache by convention; more ports allowed) onto one pipelined, word-addressed memory.
- Performs multi-word line fills for read misses and single-word write-throughs for stores.
- Arbitration is selectable between fixed priority and round-robin.

Parameters:
- NUM_PORTS, 2, number of requesting caches (>=2)
- ADDR_W, 16, word-address width
- DATA_W, 16, data word width
- WORDS_PER_LINE, 8, words per fill, power of two >=2; WL = log2(WORDS_PER_LINE)
- MEM_LATENCY, 4, fixed cycles from read issue to mem_rvalid; informational, the controller counts returns
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request; held until req_ready
- req_wr  in  NUM_PORTS  1 = single-word write, 0 = line fill
- req_addr  in  NUM_PORTS*ADDR_W  packed word addresses; port p at [p*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*DATA_W  packed write data
- req_ready  out  NUM_PORTS  one-hot grant/accept pulse
- fill_valid  out  NUM_PORTS  one-hot: fill_data valid for that port
- fill_data  out  DATA_W  returned fill word
- fill_word  out  WL  word offset within line of fill_data
- fill_done  out  NUM_PORTS  pulse with the last fill word
- wr_done  out  NUM_PORTS  pulse when a write has been issued
- busy  out  1  high whenever state != IDLE
- mem_en  out  1  memory request strobe
- mem_wr  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  read data valid, one per issued read, in issue order

Behaviour:
- Reset (async, rst_n=0): state IDLE; issue and return counters 0; owner register 0; rr pointer NUM_PORTS-1, so port 0 has first priority. All outputs 0.
- States:
  - IDLE: evaluate arbitration.
  - WR: single-word write.
  - FILL: issue reads and collect returns.
- Arbitration, IDLE only:
  - Combinational over req_valid. Winner g gets req_ready[g]=1 for that cycle.
  - Owner, address and write data are latched at the clock edge.
  - Next state is WR if req_wr[g], else FILL.
  - Fixed mode: lowest set index wins. Round-robin: first set index after rr pointer, wrapping modulo NUM_PORTS; pointer updates to g on grant.
  - No grant outside IDLE, so there is a one-cycle IDLE bubble between transactions.
- WR, exactly 1 cycle:
  - mem_en=1, mem_wr=1, mem_addr=latched addr, mem_wdata=latched data.
  - wr_done[owner]=1.
  - Next state IDLE.
- FILL:
  - Line base = latched addr with low WL bits cleared.
  - Issue counter i runs 0..WORDS_PER_LINE-1. On each of the first WORDS_PER_LINE FILL cycles: mem_en=1, mem_wr=0, mem_addr = base + i. No further issues after that.
  - Each mem_rvalid in FILL: fill_valid[owner]=1, fill_data=mem_rdata, fill_word = return counter, then the return counter increments.
  - On the return where counter == WORDS_PER_LINE-1: fill_done[owner]=1 in the same cycle, next state IDLE, counters cleared.
- Latency: request accepted at cycle T.
  - Write issues at T+1.
  - Fill issues at T+1..T+WORDS_PER_LINE; last word returns at T+WORDS_PER_LINE+MEM_LATENCY.
  - Next grant possible at the IDLE cycle after completion.
- Boundaries:
  - mem_rvalid outside FILL is ignored.
  - Return counter saturates at line size; excess rvalid is ignored.
  - Requests arriving while busy wait; a requester dropping req_valid before grant is never granted.
  - Reset mid-FILL aborts: no fill_done, and late mem_rvalid after reset is ignored.
  - Address wrap: base + i is computed modulo 2^ADDR_W.
- Width rules: mem_addr is always ADDR_W bits. mem_wdata=0 and mem_addr=0 when mem_en=0.

Test Plan:
- Single fill, port 1 addr 0x0013, WPL=8, latency 4:
  - Issue addrs 0x0010..0x0017 at T+1..T+8.
  - fill_valid[1] with fill_word 0..7 at T+5..T+12.
  - fill_done[1] at T+12.
  - busy low at T+13.
- Write, port 0 addr 0x1234 data 0xBEEF:
  - req_ready[0] at T.
  - At T+1: mem_en=mem_wr=1, addr 0x1234, wdata 0xBEEF, wr_done[0]=1.
  - IDLE at T+2.
- Simultaneous fill requests, ports 0 and 1, ARB_MODE=1, from reset:
  - Port 0 granted first.
  - Port 1 granted in the IDLE cycle after port 0's fill_done.
- ARB_MODE=0, port 0 re-requesting continuously with port 1 pending:
  - Port 0 wins every arbitration and port 1 starves.
  - The same stimulus with ARB_MODE=1 alternates 0,1,0,1.
- rst_n pulsed low after 3 fill returns:
  - All outputs 0 immediately.
  - Later mem_rvalid produces no fill_valid.
  - Next request restarts at fill_word 0.
- Wrap case, fill at addr 0xFFFE: issued addrs 0xFFF8..0xFFFF, no overflow beyond ADDR_W.
